// File: rtl/regfile_fwd_pkg.sv
// Shared constants and helpers for the forwarding register file.
// Read-port source selection is an enum so the mux priority reads as a list.
package regfile_fwd_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_NUM_REGS = 32;

   localparam logic [DEF_DATA_W-1:0] ZERO_WORD    = '0;
   localparam logic [DEF_ADDR_W-1:0] NOP_REG_ADDR = '0;

   typedef enum logic [2:0] {
      SRC_ZERO,
      SRC_EX,
      SRC_MEM,
      SRC_WB,
      SRC_ARRAY
   } rd_src_e;

endpackage

// File: rtl/regfile_fwd_rdport.sv
// One read port: resolves an operand from EX, MEM, WB or the array.
// Youngest producer wins; r0, a disabled port and reset all read as zero.
module regfile_fwd_rdport
   import regfile_fwd_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              rst,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              ex_wreg,
   input  logic [ADDR_W-1:0] ex_wd,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              mem_wreg,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] array_data,
   output logic [DATA_W-1:0] rdata
);

   rd_src_e src;

   always_comb begin
      src = SRC_ARRAY;
      if (rst || !re || raddr == '0)
         src = SRC_ZERO;
      else if (ex_wreg && ex_wd == raddr)
         src = SRC_EX;
      else if (mem_wreg && mem_wd == raddr)
         src = SRC_MEM;
      else if (we && waddr == raddr)
         src = SRC_WB;
   end

   always_comb begin
      rdata = '0;
      unique case (src)
         SRC_ZERO:  rdata = '0;
         SRC_EX:    rdata = ex_wdata;
         SRC_MEM:   rdata = mem_wdata;
         SRC_WB:    rdata = wdata;
         SRC_ARRAY: rdata = array_data;
         default:   rdata = '0;
      endcase
   end

endmodule

// File: rtl/regfile_fwd.sv
// 32-entry integer register file with EX/MEM/WB forwarding on both read
// ports and a combinational load-use stall request.
module regfile_fwd
   import regfile_fwd_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ex_wreg,
   input  logic [ADDR_W-1:0] ex_wd,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              ex_is_load,
   input  logic              mem_wreg,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic              stallreq
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   // Synchronous clear wins over a pending write; r0 is never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (we && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   regfile_fwd_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rdport1 (
      .rst        (rst),
      .re         (re1),
      .raddr      (raddr1),
      .ex_wreg    (ex_wreg),
      .ex_wd      (ex_wd),
      .ex_wdata   (ex_wdata),
      .mem_wreg   (mem_wreg),
      .mem_wd     (mem_wd),
      .mem_wdata  (mem_wdata),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .array_data (regs[raddr1]),
      .rdata      (rdata1)
   );

   regfile_fwd_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rdport2 (
      .rst        (rst),
      .re         (re2),
      .raddr      (raddr2),
      .ex_wreg    (ex_wreg),
      .ex_wd      (ex_wd),
      .ex_wdata   (ex_wdata),
      .mem_wreg   (mem_wreg),
      .mem_wd     (mem_wd),
      .mem_wdata  (mem_wdata),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .array_data (regs[raddr2]),
      .rdata      (rdata2)
   );

   // A load in EX cannot be forwarded yet, so any enabled consumer must wait.
   assign stallreq = !rst && ex_is_load && ex_wreg && (ex_wd != '0) &&
                     ((re1 && raddr1 == ex_wd) || (re2 && raddr2 == ex_wd));

endmodule
